// File: rtl/jt51_exp_pkg.sv
// Shared constants and types for the JT51 exponent ROM arbiter.
// Requester ids are sized for the largest legal requester count.
package jt51_exp_pkg;

    localparam int EXP_AW  = 5;
    localparam int EXP_DW  = 45;
    localparam int MAX_REQ = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int ID_W = clog2(MAX_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, id: '0};

endpackage

// File: rtl/jt51_rr_pick.sv
// Combinational round-robin picker: first eligible index at or above ptr,
// wrapping modulo NREQ. Returns a one-hot pick, its index and an any flag.
module jt51_rr_pick
    import jt51_exp_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] pick,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    // Scan offsets from farthest to nearest so the nearest eligible wins.
    always_comb begin
        int j;
        j    = 0;
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            j = int'(ptr) + off;
            if (j >= NREQ) j = j - NREQ;
            if (eligible[j]) begin
                pick    = '0;
                pick[j] = 1'b1;
                idx     = ID_W'(j);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jt51_exp_arb.sv
// Round-robin arbiter sharing the registered exponent ROM among NREQ
// requesters; results land in per-requester registers held until rack.
module jt51_exp_arb
    import jt51_exp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = EXP_AW,
    parameter int DW   = EXP_DW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*AW-1:0] addr,
    output logic [NREQ-1:0]  gnt,
    output logic [AW-1:0]    rom_addr,
    input  logic [DW-1:0]    rom_data,
    output logic [NREQ*DW-1:0] rdata,
    output logic [NREQ-1:0]  rvalid,
    input  logic [NREQ-1:0]  rack,
    output logic             busy
);

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] outstanding;
    logic [ID_W-1:0] pick_idx;
    logic            pick_any;
    logic            grant;
    logic [ID_W-1:0] ptr_reg;
    logic [ID_W-1:0] ptr_next;
    logic [AW-1:0]   rom_addr_reg;
    tag_t            stage1_reg;
    tag_t            stage2_reg;
    logic [AW-1:0]   addr_arr [MAX_REQ];

    // Padded to MAX_REQ entries so the id-wide index always stays in range.
    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_addr
        if (gi < NREQ) begin : g_used
            assign addr_arr[gi] = addr[gi*AW +: AW];
        end else begin : g_pad
            assign addr_arr[gi] = '0;
        end
    end

    assign eligible = req & ~outstanding;

    jt51_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_reg),
        .pick     (pick),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    assign grant    = cen & pick_any;
    assign gnt      = pick & {NREQ{grant & rst_n}};
    assign rom_addr = rom_addr_reg;
    assign busy     = stage1_reg.valid | stage2_reg.valid;

    always_comb begin
        ptr_next = ptr_reg;
        if (grant) begin
            ptr_next = (pick_idx == ID_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    // Stage 2 advances in the same cen cycle the ROM samples rom_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg      <= '0;
            rom_addr_reg <= '0;
            stage1_reg   <= TAG_IDLE;
            stage2_reg   <= TAG_IDLE;
        end else if (cen) begin
            ptr_reg    <= ptr_next;
            stage2_reg <= stage1_reg;
            stage1_reg <= '{valid: grant, id: pick_idx};
            if (grant) begin
                rom_addr_reg <= addr_arr[pick_idx];
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_res
        logic [DW-1:0] data_reg;
        logic          valid_reg;
        logic          owed_reg;
        logic          hit;
        logic          ack;

        assign hit = cen & stage2_reg.valid & (stage2_reg.id == ID_W'(gi));
        assign ack = cen & rack[gi] & valid_reg;

        // A requester cannot be re-granted until acked, so hit and ack
        // never target the same register in one cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_reg  <= '0;
                valid_reg <= 1'b0;
                owed_reg  <= 1'b0;
            end else begin
                if (hit) begin
                    data_reg  <= rom_data;
                    valid_reg <= 1'b1;
                end else if (ack) begin
                    valid_reg <= 1'b0;
                end
                if (grant && pick[gi]) begin
                    owed_reg <= 1'b1;
                end else if (ack) begin
                    owed_reg <= 1'b0;
                end
            end
        end

        assign rdata[gi*DW +: DW] = data_reg;
        assign rvalid[gi]         = valid_reg;
        assign outstanding[gi]    = owed_reg;
    end

endmodule
